// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: digit count,
// FSM encoding and the all-off pin patterns.
package sseg_scan_ctrl_pkg;

   localparam int N_DIGITS_DEF = 4;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } state_e;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
      return v[i*4 +: 4];
   endfunction

endpackage

// File: rtl/sseg_scan_ctrl_lz_mask.sv
// Leading-zero dark mask: digit k>0 goes dark when it and all nibbles above
// it are zero. Digit 0 always stays lit so a zero value still shows "0".
module lz_mask
   import sseg_scan_ctrl_pkg::*;
(
   input  logic [15:0]             value_i,
   input  logic                    lz_blank_i,
   output logic [N_DIGITS_DEF-1:0] dark_o
);

   logic z3, z2, z1;

   assign z3 = (value_i[15:12] == 4'h0);
   assign z2 = (value_i[11:8]  == 4'h0);
   assign z1 = (value_i[7:4]   == 4'h0);

   always_comb begin
      dark_o    = '0;
      dark_o[3] = lz_blank_i & z3;
      dark_o[2] = lz_blank_i & z3 & z2;
      dark_o[1] = lz_blank_i & z3 & z2 & z1;
   end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode scan controller: BLANK guard then ON dwell per
// digit, with frame-aligned commit of loaded values so a frame never tears.
module sseg_scan_ctrl
   import sseg_scan_ctrl_pkg::*;
#(
   parameter int N_DIGITS  = N_DIGITS_DEF,
   parameter int DWELL_CYC = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic        lz_blank,
   output logic        load_ack,
   output logic        busy,
   output logic [3:0]  bin_out,
   input  logic [6:0]  seg_in,
   output logic [6:0]  seg_out,
   output logic        dp_out,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   disp_val_q, disp_val_d;
   logic [3:0]    disp_dp_q, disp_dp_d;
   logic [15:0]   pend_val_q, pend_val_d;
   logic [3:0]    pend_dp_q, pend_dp_d;
   logic          pend_valid_q, pend_valid_d;
   logic          frame_start, commit, dark;
   logic [3:0]    lz_dark;

   lz_mask u_lz_mask (
      .value_i    (disp_val_q),
      .lz_blank_i (lz_blank),
      .dark_o     (lz_dark)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
               state_d = ST_ON;
               cnt_d   = '0;
            end
         end
         ST_ON: begin
            if (cnt_q == CW'(DWELL_CYC - 1)) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == 2'(N_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // Gated by reset so a reset landing on a frame start never acks a discarded load.
   assign frame_start = (state_q == ST_BLANK) && (idx_q == 2'd0) && (cnt_q == '0) && !reset;
   assign commit      = frame_start && pend_valid_q;

   always_comb begin
      pend_val_d   = load ? value : pend_val_q;
      pend_dp_d    = load ? dp_in : pend_dp_q;
      pend_valid_d = load | (pend_valid_q & ~commit);
      disp_val_d   = commit ? pend_val_q : disp_val_q;
      disp_dp_d    = commit ? pend_dp_q  : disp_dp_q;
   end

   assign dark       = ~digit_en[idx_q] | lz_dark[idx_q];
   assign bin_out    = nib(disp_val_q, idx_q);
   assign frame_tick = frame_start;
   assign load_ack   = commit;
   assign busy       = pend_valid_q;

   always_comb begin
      an      = AN_OFF;
      seg_out = SEG_OFF;
      dp_out  = 1'b1;
      if (state_q == ST_ON && !dark) begin
         an[idx_q] = 1'b0;
         seg_out   = seg_in;
         dp_out    = ~disp_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BLANK;
         idx_q        <= '0;
         cnt_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
      end
   end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 and a decoder model
// closing the bin_out -> seg_in loop; 24-cycle frames compared per cycle.
module tb_sseg_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  digit_en = 4'hF;
   logic        lz_blank = 1'b0;
   logic        load_ack, busy, dp_out, frame_tick;
   logic [3:0]  bin_out, an;
   logic [6:0]  seg_in, seg_out;

   always #5 clk = ~clk;

   function automatic logic [6:0] dec7(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
         4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
         4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
         4'hE: return 7'b0110000;  default: return 7'b0111000;
      endcase
   endfunction

   assign seg_in = dec7(bin_out);

   sseg_scan_ctrl #(.N_DIGITS(4), .DWELL_CYC(4), .BLANK_CYC(2)) dut (
      .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
      .digit_en(digit_en), .lz_blank(lz_blank), .load_ack(load_ack), .busy(busy),
      .bin_out(bin_out), .seg_in(seg_in), .seg_out(seg_out), .dp_out(dp_out),
      .an(an), .frame_tick(frame_tick)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [3:0] bin;
      logic       chk_bin;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   logic        cap_to;
   logic [3:0]  obs_an  [24];
   logic [6:0]  obs_seg [24];
   logic        obs_dp  [24];
   logic [3:0]  obs_bin [24];
   logic [23:0] obs_tick, obs_ack, obs_busy;

   // Expected per-cycle pins for one frame starting at its frame_tick cycle.
   function automatic void push_frame(input logic [15:0] v, input logic [3:0] dp,
                                      input logic [3:0] en, input logic lz);
      exp_t        x;
      int          d;
      logic        on, dk;
      logic [15:0] up;
      for (int c = 0; c < 24; c++) begin
         d  = c / 6;
         on = ((c % 6) >= 2);
         up = v >> (4 * d);
         dk = !en[d] || (lz && d > 0 && up == 16'h0);
         x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1;
         x.bin = v[4*d +: 4];
         x.chk_bin = (c != 0);
         if (on && !dk) begin
            x.an  = ~(4'b0001 << d);
            x.seg = dec7(v[4*d +: 4]);
            x.dp  = ~dp[d];
         end
         sb.push_back(x);
      end
   endfunction

   // Waits (bounded) for a frame_tick, then records 24 cycles; optionally
   // drives a load pulse in the frame_tick cycle itself.
   task automatic cap_frame(input logic ld, input logic [15:0] v, input logic [3:0] d);
      cap_to = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (frame_tick === 1'b1) begin cap_to = 1'b0; break; end
         @(negedge clk);
      end
      if (cap_to) return;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) @(negedge clk);
         obs_an[c] = an; obs_seg[c] = seg_out; obs_dp[c] = dp_out; obs_bin[c] = bin_out;
         obs_tick[c] = frame_tick; obs_ack[c] = load_ack; obs_busy[c] = busy;
         if (c == 0 && ld) begin value = v; dp_in = d; load = 1'b1; end
         if (c == 1 && ld) load = 1'b0;
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v; dp_in = d; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({an, seg_out, dp_out, busy, bin_out, load_ack, frame_tick} !==
          {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0})
         begin fails++; $display("FAIL reset_vals got an=%b seg=%b dp=%b busy=%b bin=%h ack=%b tick=%b", an, seg_out, dp_out, busy, bin_out, load_ack, frame_tick); end
      reset = 1'b0;
      #1;
      push_frame(16'h0000, 4'h0, 4'hF, 1'b0);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to) begin fails++; $display("FAIL reset_timeout got no frame_tick exp one"); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL reset_frame c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
      tests++;
      if (obs_tick !== 24'h000001 || obs_ack !== 24'h0)
         begin fails++; $display("FAIL reset_tick got tick=%h ack=%h exp 000001/000000", obs_tick, obs_ack); end
      @(negedge clk);
      tests++;
      if (frame_tick !== 1'b1) begin fails++; $display("FAIL frame_period got tick=%b exp 1 at cycle 24", frame_tick); end
   endtask

   task automatic test_load();
      repeat (3) @(negedge clk);
      do_load(16'h1234, 4'b0100);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL load_busy got %b exp 1", busy); end
      push_frame(16'h1234, 4'b0100, 4'hF, 1'b0);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to || obs_ack !== 24'h000001 || obs_busy !== 24'h000001)
         begin fails++; $display("FAIL load_ack got ack=%h busy=%h to=%b exp 000001/000001", obs_ack, obs_busy, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL load_frame c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [2];
      vals[0] = 16'h0070; vals[1] = 16'h0000;
      lz_blank = 1'b1;
      for (int k = 0; k < 2; k++) begin
         repeat (3) @(negedge clk);
         do_load(vals[k], 4'h0);
         push_frame(vals[k], 4'h0, 4'hF, 1'b1);
         cap_frame(1'b0, '0, '0);
         tests++;
         if (cap_to || obs_ack !== 24'h000001)
            begin fails++; $display("FAIL lz_ack k=%0d got ack=%h to=%b exp 000001", k, obs_ack, cap_to); end
         for (int c = 0; c < 24; c++) begin
            e = sb.pop_front(); tests++;
            if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
               begin fails++; $display("FAIL lz_frame k=%0d c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", k, c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
         end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_back_to_back();
      repeat (3) @(negedge clk);
      value = 16'hAAAA; dp_in = 4'h0; load = 1'b1;
      @(negedge clk);
      do_load(16'h5555, 4'b0010);
      push_frame(16'h5555, 4'b0010, 4'hF, 1'b0);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to || obs_ack !== 24'h000001 || obs_busy !== 24'h000001)
         begin fails++; $display("FAIL b2b_ack got ack=%h busy=%h to=%b exp 000001/000001", obs_ack, obs_busy, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL b2b_frame c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
      // Load on the commit cycle: 9876 commits now, 4321 stays pending.
      repeat (3) @(negedge clk);
      do_load(16'h9876, 4'b1000);
      push_frame(16'h9876, 4'b1000, 4'hF, 1'b0);
      push_frame(16'h4321, 4'b0001, 4'hF, 1'b0);
      cap_frame(1'b1, 16'h4321, 4'b0001);
      tests++;
      if (cap_to || obs_ack !== 24'h000001 || obs_busy !== 24'hFFFFFF)
         begin fails++; $display("FAIL tick_load_ack got ack=%h busy=%h to=%b exp 000001/ffffff", obs_ack, obs_busy, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL tick_load_f1 c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
      @(negedge clk);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to || obs_ack !== 24'h000001 || obs_busy !== 24'h000001)
         begin fails++; $display("FAIL tick_load_ack2 got ack=%h busy=%h to=%b exp 000001/000001", obs_ack, obs_busy, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL tick_load_f2 c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
   endtask

   task automatic test_digit_en();
      @(negedge clk);
      digit_en = 4'b1010;
      push_frame(16'h4321, 4'b0001, 4'b1010, 1'b0);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to || obs_tick !== 24'h000001)
         begin fails++; $display("FAIL en_tick got tick=%h to=%b exp 000001", obs_tick, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL en_frame c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
      digit_en = 4'hF;
   endtask

   task automatic test_reset_mid();
      logic seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (frame_tick === 1'b1) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      tests++;
      if (!seen) begin fails++; $display("FAIL rmid_timeout got no frame_tick exp one"); end
      repeat (2) @(negedge clk);
      do_load(16'hBEEF, 4'hF);
      repeat (12) @(negedge clk);
      tests++;
      if (an !== 4'b1011 || busy !== 1'b1)
         begin fails++; $display("FAIL rmid_pre got an=%b busy=%b exp 1011/1", an, busy); end
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({an, seg_out, dp_out, busy, bin_out, load_ack, frame_tick} !==
          {4'hF, 7'h7F, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0})
         begin fails++; $display("FAIL rmid_vals got an=%b seg=%b dp=%b busy=%b bin=%h ack=%b tick=%b", an, seg_out, dp_out, busy, bin_out, load_ack, frame_tick); end
      reset = 1'b0;
      #1;
      push_frame(16'h0000, 4'h0, 4'hF, 1'b0);
      cap_frame(1'b0, '0, '0);
      tests++;
      if (cap_to || obs_tick !== 24'h000001 || obs_ack !== 24'h0 || obs_busy !== 24'h0)
         begin fails++; $display("FAIL rmid_ack got tick=%h ack=%h busy=%h to=%b exp 000001/000000/000000", obs_tick, obs_ack, obs_busy, cap_to); end
      for (int c = 0; c < 24; c++) begin
         e = sb.pop_front(); tests++;
         if (obs_an[c] !== e.an || obs_seg[c] !== e.seg || obs_dp[c] !== e.dp || (e.chk_bin && obs_bin[c] !== e.bin))
            begin fails++; $display("FAIL rmid_frame c=%0d got an=%b seg=%b dp=%b bin=%h exp an=%b seg=%b dp=%b bin=%h", c, obs_an[c], obs_seg[c], obs_dp[c], obs_bin[c], e.an, e.seg, e.dp, e.bin); end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_lz_blank();
      test_back_to_back();
      test_digit_en();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
